timer_multi_compare: RTL and testbench

Parametrised successor to the fixed 8-bit and 16-bit timers. One up-counter of WIDTH bits with a shared prescaler and NUM_CH output-compare channels. It supports normal, CTC and fast-PWM modes, with per-source flags, a mask and a prioritised interrupt request for the control unit. Register writes arrive from the memory-map write-enable and data buses.

---
 rtl/timer_multi_compare_if.sv | 40 ++++
 rtl/timer_multi_compare.sv | 184 ++++++++++++++++++
 tb/tb_timer_multi_compare.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_multi_compare_if.sv
// Register bus and status outputs of the multi-channel compare timer.
// master: the control unit that issues register writes and observes state.
// slave : the timer itself, which drives the register readback, flags, irq and oc_out.
interface timer_multi_compare_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2
);
  // register writes
  logic                    ctrl_we;
  logic [4:0]              ctrl_wdata;   // {mode[1:0], cs[2:0]}
  logic                    tcnt_we;
  logic [WIDTH-1:0]        tcnt_wdata;
  logic [NUM_CH-1:0]       ocr_we;
  logic [WIDTH-1:0]        ocr_wdata;
  logic                    mask_we;
  logic [NUM_CH:0]         mask_wdata;
  logic [NUM_CH:0]         flag_clr;
  // state and status
  logic [4:0]              ctrl_o;
  logic [WIDTH-1:0]        tcnt_o;
  logic [NUM_CH*WIDTH-1:0] ocr_o;
  logic [NUM_CH:0]         mask_o;
  logic [NUM_CH:0]         flags_o;
  logic                    irq;
  logic [2:0]              irq_id;
  logic [NUM_CH-1:0]       oc_out;
  logic                    tick_o;

  modport master (
    output ctrl_we, ctrl_wdata, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
           mask_we, mask_wdata, flag_clr,
    input  ctrl_o, tcnt_o, ocr_o, mask_o, flags_o, irq, irq_id, oc_out, tick_o
  );

  modport slave (
    input  ctrl_we, ctrl_wdata, tcnt_we, tcnt_wdata, ocr_we, ocr_wdata,
           mask_we, mask_wdata, flag_clr,
    output ctrl_o, tcnt_o, ocr_o, mask_o, flags_o, irq, irq_id, oc_out, tick_o
  );
endinterface

// File: rtl/timer_multi_compare.sv
// Up-counter timer with shared 10-bit prescaler and NUM_CH output-compare channels.
// Latency: register writes and count/compare effects are visible one clk after the edge; irq/irq_id/tick_o are combinational.
// Backpressure: none; writes are accepted every cycle. Ports: clk, reset_n (sync, active-low), bus (slave side of timer_multi_compare_if).
module timer_multi_compare #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  timer_multi_compare_if.slave bus
);

  typedef logic [WIDTH-1:0] cnt_t;
  localparam cnt_t MAX = '1;

  logic [4:0]        ctrl_q, ctrl_d;
  logic [9:0]        pre_q, pre_d;
  cnt_t              tcnt_q, tcnt_d;
  cnt_t              ocr_q [NUM_CH];
  cnt_t              ocr_d [NUM_CH];
  cnt_t              buf_q [NUM_CH];
  cnt_t              buf_d [NUM_CH];
  logic [NUM_CH:0]   mask_q, mask_d;
  logic [NUM_CH:0]   flags_q, flags_d;
  logic [NUM_CH-1:0] oc_q, oc_d;
  logic              blk_q, blk_d;   // suppresses compare on first tick after tcnt_we

  logic [1:0]        mode;
  logic [2:0]        cs;
  logic              tick, ev, wrap, tov, pwm, leave_pwm, cs_stop;
  cnt_t              top;
  logic [NUM_CH-1:0] match;

  assign mode = ctrl_q[4:3];
  assign cs   = ctrl_q[2:0];
  assign pwm  = (mode == 2'd2);

  always_comb begin
    tick = 1'b0;
    case (cs)
      3'd1:    tick = 1'b1;
      3'd2:    tick = &pre_q[2:0];
      3'd3:    tick = &pre_q[5:0];
      3'd4:    tick = &pre_q[7:0];
      3'd5:    tick = &pre_q[9:0];
      default: tick = 1'b0;
    endcase
  end

  assign cs_stop   = (cs == 3'd0) || (cs > 3'd5);
  assign top       = (mode == 2'd1) ? ocr_q[0] : MAX;
  // A tick coinciding with tcnt_we is consumed by the write: no count, wrap or compare.
  assign ev        = tick && !bus.tcnt_we;
  assign wrap      = ev && (tcnt_q == top);
  assign tov       = wrap && (tcnt_q == MAX);
  assign leave_pwm = bus.ctrl_we && pwm && (bus.ctrl_wdata[4:3] != 2'd2);

  always_comb begin
    match = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = ev && !blk_q && (tcnt_q == ocr_q[c]);
    end
  end

  always_comb begin
    ctrl_d  = bus.ctrl_we ? bus.ctrl_wdata : ctrl_q;
    mask_d  = bus.mask_we ? bus.mask_wdata : mask_q;
    flags_d = (flags_q & ~bus.flag_clr) | {match, tov};

    if (bus.tcnt_we || (bus.ctrl_we && (bus.ctrl_wdata[2:0] != cs))) begin
      pre_d = '0;
    end else if (cs_stop) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 10'd1;
    end

    if (bus.tcnt_we) begin
      tcnt_d = bus.tcnt_wdata;
    end else if (ev) begin
      tcnt_d = wrap ? '0 : tcnt_q + cnt_t'(1);
    end else begin
      tcnt_d = tcnt_q;
    end

    if (bus.tcnt_we) begin
      blk_d = 1'b1;
    end else if (tick) begin
      blk_d = 1'b0;
    end else begin
      blk_d = blk_q;
    end

    oc_d = oc_q;
    for (int c = 0; c < NUM_CH; c++) begin
      // Buffer always follows writes so leaving/entering PWM never exposes stale data.
      buf_d[c] = bus.ocr_we[c] ? bus.ocr_wdata : buf_q[c];
      ocr_d[c] = ocr_q[c];
      if (leave_pwm) begin
        ocr_d[c] = buf_d[c];
      end else if (pwm && wrap) begin
        ocr_d[c] = buf_q[c];
      end else if (!pwm && bus.ocr_we[c]) begin
        ocr_d[c] = bus.ocr_wdata;
      end

      if (pwm) begin
        // set at TOP beats clear on match, so OCR == MAX holds the output high
        if (wrap) begin
          oc_d[c] = 1'b1;
        end else if (match[c]) begin
          oc_d[c] = 1'b0;
        end
      end else if (match[c]) begin
        oc_d[c] = ~oc_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      pre_q   <= '0;
      tcnt_q  <= '0;
      mask_q  <= '0;
      flags_q <= '0;
      oc_q    <= '0;
      blk_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ocr_q[c] <= '0;
        buf_q[c] <= '0;
      end
    end else begin
      ctrl_q  <= ctrl_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      mask_q  <= mask_d;
      flags_q <= flags_d;
      oc_q    <= oc_d;
      blk_q   <= blk_d;
      for (int c = 0; c < NUM_CH; c++) begin
        ocr_q[c] <= ocr_d[c];
        buf_q[c] <= buf_d[c];
      end
    end
  end

  logic [NUM_CH:0]         pend;
  logic [2:0]              irq_id_w;
  logic [NUM_CH*WIDTH-1:0] ocr_flat;

  assign pend = flags_q & mask_q;

  // Flag bit c+1 (OCF c) maps to id c, bit 0 (TOV) to id NUM_CH; lowest id wins.
  always_comb begin
    irq_id_w = '0;
    if (pend[0]) begin
      irq_id_w = 3'(NUM_CH);
    end
    for (int i = NUM_CH; i >= 1; i--) begin
      if (pend[i]) begin
        irq_id_w = 3'(i - 1);
      end
    end
  end

  always_comb begin
    ocr_flat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ocr_flat[c*WIDTH +: WIDTH] = ocr_q[c];
    end
  end

  assign bus.ctrl_o  = ctrl_q;
  assign bus.tcnt_o  = tcnt_q;
  assign bus.ocr_o   = ocr_flat;
  assign bus.mask_o  = mask_q;
  assign bus.flags_o = flags_q;
  assign bus.irq     = |pend;
  assign bus.irq_id  = irq_id_w;
  assign bus.oc_out  = oc_q;
  assign bus.tick_o  = tick;

endmodule

// File: tb/tb_timer_multi_compare.sv
// Scoreboard bench for timer_multi_compare (WIDTH=8, NUM_CH=2).
// The driver advances a spec-level reference model each cycle and queues the expected state;
// a monitor pops one entry just after every rising edge and compares it with the DUT.
module tb_timer_multi_compare;
  localparam int W = 8;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  timer_multi_compare_if #(.WIDTH(W), .NUM_CH(N)) bus ();
  timer_multi_compare #(.WIDTH(W), .NUM_CH(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int ctrl; int tcnt; int ocr0; int ocr1; int mask;
    int flags; int irq; int irq_id; int oc; int tick;
  } exp_t;

  exp_t expq[$];
  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int m_mode, m_cs, m_pre, m_tcnt, m_mask, m_flags, m_blk;
  int m_act[N];
  int m_buf[N];
  int m_oc[N];

  function automatic int divisor(int cs);
    case (cs)
      1: return 1;
      2: return 8;
      3: return 64;
      4: return 256;
      5: return 1024;
      default: return 0;
    endcase
  endfunction

  function automatic bit tick_of(int cs, int pre);
    int d;
    d = divisor(cs);
    return (d != 0) && ((pre % d) == d - 1);
  endfunction

  task automatic model_step();
    exp_t e;
    int pend;
    if (!reset_n) begin
      m_mode = 0; m_cs = 0; m_pre = 0; m_tcnt = 0; m_mask = 0; m_flags = 0; m_blk = 0;
      for (int c = 0; c < N; c++) begin m_act[c] = 0; m_buf[c] = 0; m_oc[c] = 0; end
    end else begin
      bit tick, ev, wrap;
      int top, set, nwd, new_mode, new_cs;
      int n_act[N];
      int n_buf[N];
      tick     = tick_of(m_cs, m_pre);
      ev       = tick && !bus.tcnt_we;
      top      = (m_mode == 1) ? m_act[0] : 255;
      wrap     = ev && (m_tcnt == top);
      new_mode = int'(bus.ctrl_wdata[4:3]);
      new_cs   = int'(bus.ctrl_wdata[2:0]);
      set      = (wrap && m_tcnt == 255) ? 1 : 0;
      nwd      = int'(bus.ocr_wdata);
      for (int c = 0; c < N; c++) begin
        bit hit;
        hit = ev && !m_blk && (m_tcnt == m_act[c]);
        if (hit) set |= (1 << (c + 1));
        if (m_mode == 2) begin
          if (wrap) m_oc[c] = 1;
          else if (hit) m_oc[c] = 0;
        end else if (hit) begin
          m_oc[c] = 1 - m_oc[c];
        end
        n_buf[c] = bus.ocr_we[c] ? nwd : m_buf[c];
        if (m_mode == 2 && bus.ctrl_we && new_mode != 2) n_act[c] = n_buf[c];
        else if (m_mode == 2 && wrap) n_act[c] = m_buf[c];
        else if (m_mode != 2 && bus.ocr_we[c]) n_act[c] = nwd;
        else n_act[c] = m_act[c];
      end
      for (int c = 0; c < N; c++) begin m_act[c] = n_act[c]; m_buf[c] = n_buf[c]; end
      m_flags = (m_flags & ~int'(bus.flag_clr)) | set;
      if (bus.tcnt_we) m_tcnt = int'(bus.tcnt_wdata);
      else if (ev) m_tcnt = (m_tcnt == top) ? 0 : (m_tcnt + 1) % 256;
      if (bus.tcnt_we || (bus.ctrl_we && new_cs != m_cs)) m_pre = 0;
      else if (divisor(m_cs) == 0) m_pre = 0;
      else m_pre = (m_pre + 1) % 1024;
      if (bus.tcnt_we) m_blk = 1;
      else if (tick) m_blk = 0;
      if (bus.ctrl_we) begin m_mode = new_mode; m_cs = new_cs; end
      if (bus.mask_we) m_mask = int'(bus.mask_wdata);
    end
    pend = m_flags & m_mask;
    e.ctrl   = m_mode * 8 + m_cs;
    e.tcnt   = m_tcnt;
    e.ocr0   = m_act[0];
    e.ocr1   = m_act[1];
    e.mask   = m_mask;
    e.flags  = m_flags;
    e.irq    = (pend != 0) ? 1 : 0;
    e.irq_id = 0;
    if (pend != 0) begin
      if ((pend & 1) != 0) e.irq_id = N;
      for (int i = N; i >= 1; i--) if ((pend & (1 << i)) != 0) e.irq_id = i - 1;
    end
    e.oc     = m_oc[0] + 2 * m_oc[1];
    e.tick   = tick_of(m_cs, m_pre) ? 1 : 0;
    expq.push_back(e);
  endtask

  task automatic chk(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("ctrl_o",  int'(bus.ctrl_o),       e.ctrl);
        chk("tcnt_o",  int'(bus.tcnt_o),       e.tcnt);
        chk("ocr0",    int'(bus.ocr_o[7:0]),   e.ocr0);
        chk("ocr1",    int'(bus.ocr_o[15:8]),  e.ocr1);
        chk("mask_o",  int'(bus.mask_o),       e.mask);
        chk("flags_o", int'(bus.flags_o),      e.flags);
        chk("irq",     int'(bus.irq),          e.irq);
        chk("irq_id",  int'(bus.irq_id),       e.irq_id);
        chk("oc_out",  int'(bus.oc_out),       e.oc);
        chk("tick_o",  int'(bus.tick_o),       e.tick);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    bus.ctrl_we = 1'b0; bus.ctrl_wdata = '0;
    bus.tcnt_we = 1'b0; bus.tcnt_wdata = '0;
    bus.ocr_we  = '0;   bus.ocr_wdata  = '0;
    bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.flag_clr = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #3;
    clear_in();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wr_ctrl(int mode, int cs);
    bus.ctrl_we = 1'b1; bus.ctrl_wdata = 5'(mode * 8 + cs); step();
  endtask
  task automatic wr_tcnt(int v);
    bus.tcnt_we = 1'b1; bus.tcnt_wdata = 8'(v); step();
  endtask
  task automatic wr_ocr(int c, int v);
    bus.ocr_we = 2'(1 << c); bus.ocr_wdata = 8'(v); step();
  endtask
  task automatic wr_mask(int v);
    bus.mask_we = 1'b1; bus.mask_wdata = 3'(v); step();
  endtask
  task automatic clr(int v);
    bus.flag_clr = 3'(v); step();
  endtask
  task automatic do_reset();
    reset_n = 1'b0; step(); reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_in();
    run(2);
    reset_n = 1'b1;
    run(2);

    // normal overflow with TOV interrupt
    wr_mask(1);
    wr_ctrl(0, 1);
    wr_tcnt(8'hFD);
    run(5);
    clr(1);
    run(3);

    // prescaler /8, then stop
    do_reset();
    wr_ctrl(0, 2);
    run(40);
    wr_ctrl(0, 0);
    run(20);

    // CTC with OCR0 = 5
    do_reset();
    wr_ocr(0, 5);
    wr_mask(7);
    wr_ctrl(1, 1);
    run(20);
    clr(7);
    run(4);

    // fast PWM: OCR1 update mid-period, OCR0 = 0 pulses, then OCR0 = MAX
    do_reset();
    wr_ctrl(2, 1);
    wr_ocr(1, 8'h80);
    run(300);
    wr_ocr(1, 8'h40);
    run(560);
    wr_ocr(0, 8'hFF);
    run(520);
    wr_ctrl(0, 1);
    run(10);

    // compare blocking after tcnt_we
    do_reset();
    wr_ctrl(0, 1);
    wr_ocr(0, 8'h10);
    wr_tcnt(8'h10);
    run(5);

    // OCF0 and OCF1 together, masked, and set colliding with clear
    wr_mask(7);
    wr_ocr(0, 8'h20);
    wr_ocr(1, 8'h20);
    wr_tcnt(8'h1E);
    run(2);
    clr(6);
    run(3);
    clr(2);
    run(2);

    // reset in mid-count with flags and oc_out set
    wr_ocr(0, 8'h30);
    wr_tcnt(8'h2E);
    run(8);
    do_reset();
    run(3);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        int cs_tab[6];
        cs_tab = '{1, 1, 1, 2, 0, 6};
        bus.ctrl_we = 1'b1;
        bus.ctrl_wdata = 5'($urandom_range(0, 3) * 8 + cs_tab[$urandom_range(0, 5)]);
      end
      if ($urandom_range(0, 79) == 0) begin
        bus.tcnt_we = 1'b1;
        bus.tcnt_wdata = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.ocr_we = 2'($urandom_range(1, 3));
        bus.ocr_wdata = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) == 0) begin
        bus.mask_we = 1'b1;
        bus.mask_wdata = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 7) == 0) bus.flag_clr = 3'($urandom_range(0, 7));
      step();
      reset_n = 1'b1;
    end

    #20;
    n_checks++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
